reg_scoreboard: RTL
===================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REG, default 32, number of architectural registers.
REQ-002 SHALL have parameter ADDRESS_SIZE, default 5, register index width.
REQ-003 SHALL have parameter TAG_SIZE, default 3, writeback tag width; max in-flight writes = 2**TAG_SIZE.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 iss_valid  in  1  issue stage presents an instruction.
REQ-007 iss_rs1, iss_rs2  in  ADDRESS_SIZE each  source register indices.
REQ-008 iss_rd  in  ADDRESS_SIZE  destination register index.
REQ-009 iss_rd_wen  in  1  instruction writes iss_rd.
REQ-010 iss_ready  out  1  combinational; no hazard, instruction may issue.
REQ-011 iss_tag  out  TAG_SIZE  tag assigned to an accepted writing instruction; equals the tag counter.
REQ-012 wb_valid  in  1  writeback stage writes the register file this cycle.
REQ-013 wb_rd  in  ADDRESS_SIZE; wb_tag  in  TAG_SIZE  writeback destination and its issue tag.
REQ-014 flush  in  1  discard all in-flight writes.
REQ-015 busy_cnt  out  ADDRESS_SIZE+1  registered count of busy registers.
REQ-016 inflight  out  TAG_SIZE+1  registered count of outstanding writes.
REQ-017 wb_err  out  1  registered one-cycle pulse: wb_valid seen while inflight == 0.

Function
REQ-018 SHALL hold per register a busy bit and a TAG_SIZE tag; register 0 SHALL never be busy.
REQ-019 iss_ready = !flush AND !(busy[rs1] AND rs1!=0) AND !(busy[rs2] AND rs2!=0) AND !(iss_rd_wen AND inflight == 2**TAG_SIZE).
REQ-020 No same-cycle bypass: a source cleared by this cycle's writeback SHALL still stall this cycle; it becomes ready the next cycle.
REQ-021 Accept = iss_valid AND iss_ready; only when accept AND iss_rd_wen AND iss_rd!=0: busy[rd]<=1, tag[rd]<=tag counter, tag counter += 1 (wraps modulo 2**TAG_SIZE), inflight += 1.
REQ-022 Accept with iss_rd_wen AND iss_rd==0 SHALL change no state except inflight/tag counter unchanged; no wb is expected.
REQ-023 WAW SHALL NOT stall: re-issuing to a busy rd overwrites its tag.
REQ-024 On wb_valid: if busy[wb_rd] AND tag[wb_rd]==wb_tag, clear busy[wb_rd]; otherwise (superseded/stale) leave busy unchanged.
REQ-025 Every wb_valid with inflight>0 SHALL decrement inflight, whether tag matches or not.
REQ-026 Simultaneous accept and wb in one cycle: inflight net unchanged; if same rd, issue wins (busy stays 1, new tag).
REQ-027 wb_valid with inflight==0 SHALL leave all state unchanged and set wb_err for exactly the next cycle.
REQ-028 flush SHALL clear all busy bits and inflight to 0 at the next edge; tag counter unchanged; same-cycle wb ignored.
REQ-029 busy_cnt SHALL equal the popcount of busy bits after each edge (range 0..NUM_REG-1).

Reset
REQ-030 On rst_n low, immediately: all busy bits 0, all tags 0, tag counter 0, inflight 0, busy_cnt 0, wb_err 0; iss_ready follows REQ-019 (1 when flush low).
REQ-031 Reset deassertion mid-operation SHALL lose all in-flight tracking; pipeline is flushed externally.

Structure
REQ-032 NUM_REG, ADDRESS_SIZE, TAG_SIZE defaults SHALL live in a shared CPU parameter package used with the register file.
REQ-033 Sub-module popcount (combinational busy-bit counter) SHALL be a separate module; all else in one module.

Verification
REQ-034 Issue rd=5 wen, tag 0; next cycle issue rs1=5 -> iss_ready=0; wb rd=5 tag=0 -> ready=1 following cycle.
REQ-035 Issue rd=7 (tag 1), issue rd=7 (tag 2); wb rd=7 tag=1 -> busy stays, inflight 2->1; wb tag=2 -> busy clears, inflight 0.
REQ-036 Eight writing issues without wb -> inflight=8, writing issue ready=0, non-writing independent issue ready=1; tag counter wraps to 0.
REQ-037 Issue rd=0 wen, then rs1=0 -> ready=1, busy_cnt=0, inflight unchanged.
REQ-038 Three busy regs, assert flush -> iss_ready=0 that cycle; next cycle busy_cnt=0, inflight=0.
REQ-039 wb_valid with inflight=0 -> wb_err=1 one cycle; async rst_n low mid-run -> all outputs at REQ-030 values without clock edge.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_pkg
// Shared CPU parameter package. Holds the architectural register-file
// geometry and the writeback tag width. The register file and the scoreboard
// both take their defaults from here so the two can never disagree.
// -----------------------------------------------------------------------------
package reg_scoreboard_pkg;

    // Number of architectural registers (register 0 is hard-wired zero).
    localparam int CPU_NUM_REG      = 32;
    // Width of a register index.
    localparam int CPU_ADDRESS_SIZE = 5;
    // Width of a writeback tag; 2**CPU_TAG_SIZE writes may be outstanding.
    localparam int CPU_TAG_SIZE     = 3;

endpackage : reg_scoreboard_pkg

// File: rtl/reg_scoreboard_if.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_if
// Issue / writeback / flush bus between the pipeline and the scoreboard.
//   master : pipeline side (drives issue request, writeback, flush)
//   slave  : scoreboard side (returns iss_ready and iss_tag)
// Signals:
//   iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_wen : issue request
//   iss_ready, iss_tag                              : issue response
//   wb_valid, wb_rd, wb_tag                         : register-file writeback
//   flush                                           : drop all in-flight writes
// -----------------------------------------------------------------------------
interface reg_scoreboard_if
    import reg_scoreboard_pkg::*;
#(
    parameter int ADDRESS_SIZE = CPU_ADDRESS_SIZE,
    parameter int TAG_SIZE     = CPU_TAG_SIZE
) ();

    logic                    iss_valid;
    logic [ADDRESS_SIZE-1:0] iss_rs1;
    logic [ADDRESS_SIZE-1:0] iss_rs2;
    logic [ADDRESS_SIZE-1:0] iss_rd;
    logic                    iss_rd_wen;
    logic                    iss_ready;
    logic [TAG_SIZE-1:0]     iss_tag;

    logic                    wb_valid;
    logic [ADDRESS_SIZE-1:0] wb_rd;
    logic [TAG_SIZE-1:0]     wb_tag;

    logic                    flush;

    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_wen,
        output wb_valid, wb_rd, wb_tag, flush,
        input  iss_ready, iss_tag
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_wen,
        input  wb_valid, wb_rd, wb_tag, flush,
        output iss_ready, iss_tag
    );

endinterface : reg_scoreboard_if

// File: rtl/reg_scoreboard_popcount.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_popcount
// Combinational population count of a bit vector.
// Ports:
//   bits_i  [N-1:0] : vector to count
//   count_o [W-1:0] : number of ones in bits_i
// -----------------------------------------------------------------------------
module reg_scoreboard_popcount #(
    parameter int N = 32,
    parameter int W = 6
) (
    input  logic [N-1:0] bits_i,
    output logic [W-1:0] count_o
);

    always_comb begin
        // NOTE: assign a default before any conditional/loop update so every
        // path writes the output and no latch is inferred.
        count_o = '0;
        for (int i = 0; i < N; i++) begin
            count_o = count_o + W'(bits_i[i]);
        end
    end

endmodule : reg_scoreboard_popcount

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Register scoreboard for an in-order issue pipeline. Tracks, per register,
// whether a write is outstanding and which issue tag owns it, so that RAW
// hazards stall issue while WAW re-issues simply take over the register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   sb          : issue / writeback / flush bus (slave side)
//   busy_cnt    : registered number of busy registers
//   inflight    : registered number of outstanding writes
//   wb_err      : registered one-cycle pulse, writeback with nothing in flight
// -----------------------------------------------------------------------------
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REG      = CPU_NUM_REG,
    parameter int ADDRESS_SIZE = CPU_ADDRESS_SIZE,
    parameter int TAG_SIZE     = CPU_TAG_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_scoreboard_if.slave       sb,
    output logic [ADDRESS_SIZE:0] busy_cnt,
    output logic [TAG_SIZE:0]     inflight,
    output logic                  wb_err
);

    // Outstanding-write limit: one per distinct tag value.
    localparam logic [TAG_SIZE:0] INFLIGHT_MAX = {1'b1, {TAG_SIZE{1'b0}}};

    logic [NUM_REG-1:0]    busy_q,     busy_d;
    logic [TAG_SIZE-1:0]   tag_q [NUM_REG];
    logic [TAG_SIZE-1:0]   tag_d [NUM_REG];
    logic [TAG_SIZE-1:0]   tag_cnt_q,  tag_cnt_d;
    logic [TAG_SIZE:0]     inflight_q, inflight_d;
    logic                  wb_err_q,   wb_err_d;
    logic [ADDRESS_SIZE:0] busy_cnt_q, busy_cnt_d;

    logic rs1_hazard, rs2_hazard, full_stall;
    logic accept, alloc;

    // ---------------------------------------------------------------- issue
    // Hazards look only at registered busy bits: a writeback landing this
    // cycle does not bypass, the dependent instruction issues next cycle.
    assign rs1_hazard = busy_q[sb.iss_rs1] && (sb.iss_rs1 != '0);
    assign rs2_hazard = busy_q[sb.iss_rs2] && (sb.iss_rs2 != '0);
    assign full_stall = sb.iss_rd_wen && (inflight_q == INFLIGHT_MAX);

    assign sb.iss_ready = !sb.flush && !rs1_hazard && !rs2_hazard && !full_stall;
    assign sb.iss_tag   = tag_cnt_q;

    assign accept = sb.iss_valid && sb.iss_ready;
    // Writes to register 0 are discarded by the register file, so they are
    // neither tracked nor counted as in flight.
    assign alloc  = accept && sb.iss_rd_wen && (sb.iss_rd != '0);

    // ----------------------------------------------------------- next state
    always_comb begin
        busy_d     = busy_q;
        tag_d      = tag_q;
        tag_cnt_d  = tag_cnt_q;
        inflight_d = inflight_q;
        wb_err_d   = 1'b0;

        if (sb.flush) begin
            // Tag counter keeps running so post-flush tags stay distinct
            // from any late writebacks of the discarded instructions.
            busy_d     = '0;
            inflight_d = '0;
        end else begin
            if (sb.wb_valid) begin
                if (inflight_q == '0) begin
                    wb_err_d = 1'b1;
                end else begin
                    inflight_d = inflight_d - 1'b1;
                    // Only the newest writer of a register may release it;
                    // superseded (WAW) writebacks leave it busy.
                    if (busy_q[sb.wb_rd] && (tag_q[sb.wb_rd] == sb.wb_tag)) begin
                        busy_d[sb.wb_rd] = 1'b0;
                    end
                end
            end
            // Applied after the writeback so a same-register issue wins.
            if (alloc) begin
                busy_d[sb.iss_rd] = 1'b1;
                tag_d[sb.iss_rd]  = tag_cnt_q;
                tag_cnt_d         = tag_cnt_q + 1'b1;
                inflight_d        = inflight_d + 1'b1;
            end
        end

        busy_d[0] = 1'b0;
    end

    reg_scoreboard_popcount #(
        .N (NUM_REG),
        .W (ADDRESS_SIZE + 1)
    ) u_popcount (
        .bits_i  (busy_d),
        .count_o (busy_cnt_d)
    );

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            tag_cnt_q  <= '0;
            inflight_q <= '0;
            wb_err_q   <= 1'b0;
            busy_cnt_q <= '0;
            // NOTE: the tag array is reset on purpose: every tag is defined
            // as 0 after reset, not just the busy bits that qualify them.
            for (int i = 0; i < NUM_REG; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the pre-edge values of the others.
            busy_q     <= busy_d;
            tag_q      <= tag_d;
            tag_cnt_q  <= tag_cnt_d;
            inflight_q <= inflight_d;
            wb_err_q   <= wb_err_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;
    assign inflight = inflight_q;
    assign wb_err   = wb_err_q;

endmodule : reg_scoreboard
